shift_arbiter: RTL and testbench
================================

# shift_arbiter

Two-requester scheduler for the shared 32-bit shift datapath (`sll_32` left shifter, `slr_32` logical right shifter). The block arbitrates round-robin between the EX-stage ALU (requester 0) and the load/store byte-alignment path (requester 1). It composes SLL/SRL/SRA from the logical shifters and returns tagged results through a 2-stage valid/ready pipeline with full backpressure and throughput of one request per cycle.

## Interface
- `TAG_WIDTH`, 4, width of requester-supplied tag returned with each result
- `CLK` in 1 — single clock; all state updates on rising edge
- `RESET` in 1 — synchronous, active-high
- `REQ0_VALID` in 1 — requester 0 has a shift request
- `REQ0_READY` out 1 — requester 0 request accepted this cycle when both VALID and READY are high
- `REQ0_DATA` in 32 — operand
- `REQ0_SHAMT` in 5 — shift amount
- `REQ0_OP` in 2 — 00 SLL, 01 SRL, 10 SRA, 11 pass-through
- `REQ0_TAG` in TAG_WIDTH — opaque tag
- `REQ1_VALID`, `REQ1_READY`, `REQ1_DATA`, `REQ1_SHAMT`, `REQ1_OP`, `REQ1_TAG` — same as requester 0
- `RESP_VALID` out 1 — result available
- `RESP_READY` in 1 — consumer accepts result
- `RESP_DATA` out 32 — shifted result
- `RESP_ID` out 1 — index of the originating requester
- `RESP_TAG` out TAG_WIDTH — tag of the originating request

## Operation
- Stage A (operand register): holds `a_valid`, data, shamt, op, id, tag of the granted request.
- Stage B (result register): holds `RESP_VALID`, `RESP_DATA`, `RESP_ID`, `RESP_TAG`.
- `b_free = !RESP_VALID | RESP_READY`; `a_free = !a_valid | b_free`.
- Arbitration is combinational and round-robin with pointer `rr` (reset 0):
  - If only one VALID is high, that requester is granted.
  - If both are high, requester `rr` is granted.
  - `REQi_READY = grant_i & a_free`. At most one READY is high per cycle. READY is 0 when the requester is not VALID.
  - On acceptance from requester i, `rr <= !i`. Otherwise `rr` holds.
- Datapath is computed from stage A:
  - SLL = `sll_32(data, shamt)`.
  - SRL = `slr_32(data, shamt)`.
  - SRA = SRL | (data[31] ? ~`slr_32(32'hFFFFFFFF, shamt)` : 0).
  - OP 11 = data.
  - SHAMT 0 returns data unchanged for every OP.
- Stage B loads the computed result, id and tag when `a_valid & b_free`; `RESP_VALID <= 1`.
- When `RESP_VALID & RESP_READY` and stage A is empty, `RESP_VALID <= 0`.
- Stage A loads on acceptance. It clears when it advances into B with no new acceptance in the same cycle.
- Requesters must hold all REQ fields stable while VALID is high and READY is low. VALID must not depend combinationally on READY.
- While `RESP_VALID & !RESP_READY`, `RESP_*` are held stable.

## Timing
- Reset (RESET high at a rising edge) sets:
  - `a_valid=0`, `RESP_VALID=0`, `RESP_DATA=0`, `RESP_ID=0`, `RESP_TAG=0`, `rr=0`.
  - READY outputs are 0 in the reset cycle.
- Reset mid-operation discards in-flight requests in both stages. No response is produced for them.
- Latency: a request accepted at edge N gives `RESP_VALID=1` after edge N+1 (2-cycle pipeline).
- Throughput: with `RESP_READY` held high, one acceptance per cycle, sustained.
- Backpressure with `RESP_READY=0` and both stages full:
  - Both READYs go low.
  - When `RESP_READY` rises, B drains, A moves into B, and a new request is accepted in the same cycle.
- Simultaneous B drain, A→B advance and new acceptance in one cycle is legal and loses nothing.
- Starvation bound: a requester holding VALID is accepted within 2 acceptances.

## Test plan
- Reset, then REQ0 SLL data=0x0000_0001 shamt=31 tag=3, `RESP_READY=1`
  - `RESP_DATA=0x8000_0000`, ID=0, TAG=3, RESP_VALID exactly 2 cycles after acceptance.
- REQ1 SRA data=0x8000_0000 shamt=4 → 0xF800_0000.
- SRL same operands → 0x0800_0000.
- SRA data=0x7FFF_FFFF shamt=31 → 0x0000_0000.
- OP 11 data=0x1234_5678 → 0x1234_5678.
- Both VALID continuously for 6 cycles, `RESP_READY=1`:
  - Grants alternate 0,1,0,1,0,1.
  - RESP_ID sequence matches, one response per cycle.
- `RESP_READY=0` for 4 cycles while both request:
  - Exactly 2 acceptances, then both READY=0.
  - RESP_DATA/ID/TAG stable during the stall.
  - After release, responses emerge in acceptance order with no loss or duplication.
- RESET asserted for 1 cycle with both stages full:
  - Next cycle RESP_VALID=0, RESP_DATA=0, `rr=0`.
  - Stale results never appear.
  - Subsequent simultaneous request grants REQ0 first.

Source files
------------

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin two-requester front end for the shared 32-bit shift datapath
module shift_arbiter #(
  parameter int TAG_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REQ0_VALID,
  output logic                 REQ0_READY,
  input  logic [31:0]          REQ0_DATA,
  input  logic [4:0]           REQ0_SHAMT,
  input  logic [1:0]           REQ0_OP,
  input  logic [TAG_WIDTH-1:0] REQ0_TAG,
  input  logic                 REQ1_VALID,
  output logic                 REQ1_READY,
  input  logic [31:0]          REQ1_DATA,
  input  logic [4:0]           REQ1_SHAMT,
  input  logic [1:0]           REQ1_OP,
  input  logic [TAG_WIDTH-1:0] REQ1_TAG,
  output logic                 RESP_VALID,
  input  logic                 RESP_READY,
  output logic [31:0]          RESP_DATA,
  output logic                 RESP_ID,
  output logic [TAG_WIDTH-1:0] RESP_TAG
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  function automatic logic [31:0] sll_32(input logic [31:0] d, input logic [4:0] s);
    logic [31:0] r;
    r = d;
    if (s[0]) r = {r[30:0], 1'b0};
    if (s[1]) r = {r[29:0], 2'b0};
    if (s[2]) r = {r[27:0], 4'b0};
    if (s[3]) r = {r[23:0], 8'b0};
    if (s[4]) r = {r[15:0], 16'b0};
    return r;
  endfunction

  function automatic logic [31:0] slr_32(input logic [31:0] d, input logic [4:0] s);
    logic [31:0] r;
    r = d;
    if (s[0]) r = {1'b0, r[31:1]};
    if (s[1]) r = {2'b0, r[31:2]};
    if (s[2]) r = {4'b0, r[31:4]};
    if (s[3]) r = {8'b0, r[31:8]};
    if (s[4]) r = {16'b0, r[31:16]};
    return r;
  endfunction

  // stage A: operands of the granted request
  logic                 a_valid;
  logic [31:0]          a_data;
  logic [4:0]           a_shamt;
  logic [1:0]           a_op;
  logic                 a_id;
  logic [TAG_WIDTH-1:0] a_tag;

  logic rr;
  logic b_free, a_free;
  logic grant0, grant1;
  logic acc0, acc1, accept;
  logic a_advance;

  logic [31:0]          sel_data;
  logic [4:0]           sel_shamt;
  logic [1:0]           sel_op;
  logic [TAG_WIDTH-1:0] sel_tag;

  logic [31:0] srl_res;
  logic [31:0] sra_fill;
  logic [31:0] result;

  assign b_free    = ~RESP_VALID | RESP_READY;
  assign a_free    = ~a_valid | b_free;
  assign a_advance = a_valid & b_free;

  // when both ask, rr names the requester that goes first
  assign grant0 = REQ0_VALID & (~REQ1_VALID | ~rr);
  assign grant1 = REQ1_VALID & (~REQ0_VALID |  rr);

  assign REQ0_READY = grant0 & a_free & ~RESET;
  assign REQ1_READY = grant1 & a_free & ~RESET;
  assign acc0       = REQ0_VALID & REQ0_READY;
  assign acc1       = REQ1_VALID & REQ1_READY;
  assign accept     = acc0 | acc1;

  always_comb begin
    sel_data  = REQ0_DATA;
    sel_shamt = REQ0_SHAMT;
    sel_op    = REQ0_OP;
    sel_tag   = REQ0_TAG;
    if (acc1) begin
      sel_data  = REQ1_DATA;
      sel_shamt = REQ1_SHAMT;
      sel_op    = REQ1_OP;
      sel_tag   = REQ1_TAG;
    end
  end

  // SRA is built from the logical shifter: the vacated high bits come from an
  // all-ones word shifted right and inverted.
  always_comb begin
    srl_res  = slr_32(a_data, a_shamt);
    sra_fill = a_data[31] ? ~slr_32(32'hFFFF_FFFF, a_shamt) : 32'h0;
    result   = a_data;
    case (a_op)
      OP_SLL:  result = sll_32(a_data, a_shamt);
      OP_SRL:  result = srl_res;
      OP_SRA:  result = srl_res | sra_fill;
      OP_PASS: result = a_data;
      default: result = a_data;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr      <= 1'b0;
      a_valid <= 1'b0;
      a_data  <= 32'h0;
      a_shamt <= 5'h0;
      a_op    <= 2'b00;
      a_id    <= 1'b0;
      a_tag   <= '0;
    end else begin
      if (accept) begin
        rr      <= acc0;
        a_valid <= 1'b1;
        a_data  <= sel_data;
        a_shamt <= sel_shamt;
        a_op    <= sel_op;
        a_id    <= acc1;
        a_tag   <= sel_tag;
      end else if (a_advance) begin
        a_valid <= 1'b0;
      end
    end
  end

  // stage B: result register, held while the consumer stalls
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RESP_VALID <= 1'b0;
      RESP_DATA  <= 32'h0;
      RESP_ID    <= 1'b0;
      RESP_TAG   <= '0;
    end else begin
      if (a_advance) begin
        RESP_VALID <= 1'b1;
        RESP_DATA  <= result;
        RESP_ID    <= a_id;
        RESP_TAG   <= a_tag;
      end else if (RESP_VALID && RESP_READY) begin
        RESP_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - bench for shift_arbiter: queue-based reference model plus directed literals
module tb_shift_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ0_VALID, REQ0_READY;
  logic [31:0] REQ0_DATA;
  logic [4:0]  REQ0_SHAMT;
  logic [1:0]  REQ0_OP;
  logic [3:0]  REQ0_TAG;
  logic        REQ1_VALID, REQ1_READY;
  logic [31:0] REQ1_DATA;
  logic [4:0]  REQ1_SHAMT;
  logic [1:0]  REQ1_OP;
  logic [3:0]  REQ1_TAG;
  logic        RESP_VALID, RESP_READY;
  logic [31:0] RESP_DATA;
  logic        RESP_ID;
  logic [3:0]  RESP_TAG;

  shift_arbiter #(.TAG_WIDTH(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_DATA(REQ0_DATA),
    .REQ0_SHAMT(REQ0_SHAMT), .REQ0_OP(REQ0_OP), .REQ0_TAG(REQ0_TAG),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_DATA(REQ1_DATA),
    .REQ1_SHAMT(REQ1_SHAMT), .REQ1_OP(REQ1_OP), .REQ1_TAG(REQ1_TAG),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_DATA(RESP_DATA),
    .RESP_ID(RESP_ID), .RESP_TAG(RESP_TAG)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] data; logic [4:0] shamt; logic [1:0] op; logic [3:0] tag; } req_t;
  typedef struct { logic [31:0] data; logic id; logic [3:0] tag; int acc; } item_t;
  typedef struct { logic [31:0] data; logic id; logic [3:0] tag; int acc; int done; } log_t;

  req_t  q0[$], q1[$];
  item_t expq[$];
  log_t  rlog[$];

  int errors = 0;
  int checks = 0;
  int edges = 0;
  int acc_count = 0;
  logic rr_m = 1'b0;
  logic took0 = 1'b0, took1 = 1'b0;
  logic prev_stall = 1'b0;
  logic [31:0] p_data;
  logic p_id;
  logic [3:0] p_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, edges);
    end
  endtask

  function automatic logic [31:0] model_shift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  // requester drivers: present the head of each queue, drop it once taken
  always @(posedge CLK) begin
    #1;
    if (took0 && q0.size() > 0) q0.delete(0);
    if (took1 && q1.size() > 0) q1.delete(0);
    took0 = 1'b0;
    took1 = 1'b0;
    if (q0.size() > 0) begin
      REQ0_VALID = 1'b1; REQ0_DATA = q0[0].data; REQ0_SHAMT = q0[0].shamt;
      REQ0_OP = q0[0].op; REQ0_TAG = q0[0].tag;
    end else REQ0_VALID = 1'b0;
    if (q1.size() > 0) begin
      REQ1_VALID = 1'b1; REQ1_DATA = q1[0].data; REQ1_SHAMT = q1[0].shamt;
      REQ1_OP = q1[0].op; REQ1_TAG = q1[0].tag;
    end else REQ1_VALID = 1'b0;
  end

  // compare process: model decides what the coming edge must do
  always @(negedge CLK) begin
    logic g0, g1, can, er0, er1, erv;
    if (RESET) begin
      chk("ready_in_reset", 32'({REQ1_READY, REQ0_READY}), 32'h0);
      expq.delete();
      rr_m = 1'b0;
      prev_stall = 1'b0;
      took0 = 1'b0;
      took1 = 1'b0;
    end else begin
      g0  = REQ0_VALID && (!REQ1_VALID || !rr_m);
      g1  = REQ1_VALID && (!REQ0_VALID || rr_m);
      can = (expq.size() < 2) || RESP_READY;
      er0 = g0 && can;
      er1 = g1 && can;
      chk("req0_ready", 32'(REQ0_READY), 32'(er0));
      chk("req1_ready", 32'(REQ1_READY), 32'(er1));
      erv = (expq.size() > 0) && (edges >= expq[0].acc + 1);
      chk("resp_valid", 32'(RESP_VALID), 32'(erv));
      if (erv && RESP_VALID) begin
        chk("resp_data", RESP_DATA, expq[0].data);
        chk("resp_id", 32'(RESP_ID), 32'(expq[0].id));
        chk("resp_tag", 32'(RESP_TAG), 32'(expq[0].tag));
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(RESP_VALID), 32'h1);
        chk("stall_data", RESP_DATA, p_data);
        chk("stall_id", 32'(RESP_ID), 32'(p_id));
        chk("stall_tag", 32'(RESP_TAG), 32'(p_tag));
      end
      prev_stall = RESP_VALID && !RESP_READY;
      p_data = RESP_DATA; p_id = RESP_ID; p_tag = RESP_TAG;
      took0 = REQ0_VALID && REQ0_READY;
      took1 = REQ1_VALID && REQ1_READY;
      if (erv && RESP_READY) begin
        rlog.push_back('{data: expq[0].data, id: expq[0].id, tag: expq[0].tag,
                         acc: expq[0].acc, done: edges + 1});
        expq.delete(0);
      end
      if (er0) begin
        expq.push_back('{data: model_shift(REQ0_DATA, REQ0_SHAMT, REQ0_OP), id: 1'b0,
                         tag: REQ0_TAG, acc: edges + 1});
        rr_m = 1'b1;
        acc_count++;
      end else if (er1) begin
        expq.push_back('{data: model_shift(REQ1_DATA, REQ1_SHAMT, REQ1_OP), id: 1'b1,
                         tag: REQ1_TAG, acc: edges + 1});
        rr_m = 1'b0;
        acc_count++;
      end
    end
    edges++;
  end

  task automatic tick();
    @(posedge CLK);
    #3;
  endtask

  task automatic push(input int who, input logic [31:0] d, input logic [4:0] s,
                      input logic [1:0] op, input logic [3:0] tag);
    req_t r;
    r = '{data: d, shamt: s, op: op, tag: tag};
    if (who == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && expq.size() == 0 && !REQ0_VALID && !REQ1_VALID)
        return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout, %0d responses still outstanding (required 0)", name, expq.size());
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (required finish)");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    int ac;
    RESET = 1'b1; RESP_READY = 1'b1;
    REQ0_VALID = 1'b0; REQ0_DATA = '0; REQ0_SHAMT = '0; REQ0_OP = '0; REQ0_TAG = '0;
    REQ1_VALID = 1'b0; REQ1_DATA = '0; REQ1_SHAMT = '0; REQ1_OP = '0; REQ1_TAG = '0;
    repeat (2) tick();
    RESET = 1'b0;
    chk("rst_resp_valid", 32'(RESP_VALID), 32'h0);
    chk("rst_resp_data", RESP_DATA, 32'h0);
    chk("rst_resp_id", 32'(RESP_ID), 32'h0);
    chk("rst_resp_tag", 32'(RESP_TAG), 32'h0);

    base = rlog.size();
    push(0, 32'h0000_0001, 5'd31, 2'b00, 4'd3);
    wait_idle("t1");
    push(1, 32'h8000_0000, 5'd4, 2'b10, 4'd5);
    wait_idle("t2");
    push(1, 32'h8000_0000, 5'd4, 2'b01, 4'd6);
    wait_idle("t3");
    push(0, 32'h7FFF_FFFF, 5'd31, 2'b10, 4'd7);
    wait_idle("t4");
    push(1, 32'h1234_5678, 5'd9, 2'b11, 4'd8);
    wait_idle("t5");
    if (rlog.size() - base == 5) begin
      chk("t1_data", rlog[base].data, 32'h8000_0000);
      chk("t1_id", 32'(rlog[base].id), 32'h0);
      chk("t1_tag", 32'(rlog[base].tag), 32'h3);
      chk("t1_latency", 32'(rlog[base].done - rlog[base].acc), 32'h2);
      chk("t2_sra", rlog[base+1].data, 32'hF800_0000);
      chk("t3_srl", rlog[base+2].data, 32'h0800_0000);
      chk("t4_sra_pos", rlog[base+3].data, 32'h0000_0000);
      chk("t5_pass", rlog[base+4].data, 32'h1234_5678);
    end else chk("t1_t5_count", 32'(rlog.size() - base), 32'h5);

    base = rlog.size();
    for (int i = 0; i < 3; i++) begin
      push(0, 32'hA5A5_0000 + i, 5'(i + 1), 2'(i), 4'(2 * i));
      push(1, 32'hC300_00F0 + i, 5'(i + 3), 2'(2 - i), 4'(2 * i + 1));
    end
    wait_idle("t6");
    chk("t6_count", 32'(rlog.size() - base), 32'h6);
    if (rlog.size() - base == 6)
      for (int i = 0; i < 6; i++) begin
        chk("t6_id", 32'(rlog[base+i].id), 32'(i % 2));
        chk("t6_back2back", 32'(rlog[base+i].done - rlog[base].done), 32'(i));
      end

    base = rlog.size();
    ac = acc_count;
    RESP_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(0, 32'h0F0F_1234 << i, 5'(7 * i), 2'b10, 4'(8 + 2 * i));
      push(1, 32'hF000_0001 >> i, 5'(5 * i + 1), 2'b01, 4'(9 + 2 * i));
    end
    repeat (4) tick();
    chk("t7_stall_accepts", 32'(acc_count - ac), 32'h2);
    RESP_READY = 1'b1;
    wait_idle("t7");
    chk("t7_count", 32'(rlog.size() - base), 32'h6);
    if (rlog.size() - base == 6)
      for (int i = 0; i < 6; i++) begin
        chk("t7_id", 32'(rlog[base+i].id), 32'(i % 2));
        chk("t7_tag", 32'(rlog[base+i].tag), 32'(8 + i));
      end

    RESP_READY = 1'b0;
    push(0, 32'hDEAD_BEEF, 5'd1, 2'b00, 4'd14);
    push(1, 32'hCAFE_F00D, 5'd2, 2'b01, 4'd15);
    push(0, 32'h1111_2222, 5'd3, 2'b10, 4'd13);
    push(1, 32'h3333_4444, 5'd4, 2'b11, 4'd12);
    for (int i = 0; i < 20 && expq.size() < 2; i++) tick();
    chk("t8_full_before_reset", 32'(expq.size()), 32'h2);
    RESET = 1'b1;
    q0.delete();
    q1.delete();
    tick();
    RESET = 1'b0;
    chk("t8_resp_valid", 32'(RESP_VALID), 32'h0);
    chk("t8_resp_data", RESP_DATA, 32'h0);
    base = rlog.size();
    RESP_READY = 1'b1;
    push(0, 32'h0000_00FF, 5'd8, 2'b00, 4'd6);
    push(1, 32'hFF00_0000, 5'd8, 2'b10, 4'd7);
    wait_idle("t8");
    chk("t8_count", 32'(rlog.size() - base), 32'h2);
    if (rlog.size() - base == 2) begin
      chk("t8_first_id", 32'(rlog[base].id), 32'h0);
      chk("t8_first_data", rlog[base].data, 32'h0000_FF00);
      chk("t8_second_id", 32'(rlog[base+1].id), 32'h1);
      chk("t8_second_data", rlog[base+1].data, 32'hFFFF_0000);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
